// File: rtl/state_register_pkg.sv
// Shared defaults and the legality helper for state_register.
package state_register_pkg;

  localparam int unsigned DEF_STATE_W     = 3;
  localparam int unsigned DEF_NUM_STATES  = 8;
  localparam int unsigned DEF_RESET_STATE = 0;
  localparam int unsigned DEF_DWELL_W     = 8;

  // An encoding is legal when it falls inside 0..numStates-1.
  function automatic logic is_legal(input int unsigned enc, input int unsigned numStates);
    return enc < numStates;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating up-counter, cleared synchronously by reset or clr.
module dwell_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_COUNT = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != MAX_COUNT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/state_register.sv
// Present-state register with previous-state history, change pulse and sticky illegal flag.
// Optional dwell counter and dwell_count port exist only when STATE_REGISTER_DWELL_EN is defined.
module state_register
  import state_register_pkg::*;
#(
  parameter int unsigned STATE_W     = DEF_STATE_W,
  parameter int unsigned NUM_STATES  = DEF_NUM_STATES,
  parameter int unsigned RESET_STATE = DEF_RESET_STATE,
  parameter int unsigned DWELL_W     = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [STATE_W-1:0] next_state,
  input  logic               clear_illegal,
  output logic [STATE_W-1:0] current_state,
  output logic [STATE_W-1:0] prev_state,
  output logic               state_changed,
  output logic               illegal_flag
`ifdef STATE_REGISTER_DWELL_EN
  ,
  output logic [DWELL_W-1:0] dwell_count
`endif
);

  localparam logic [STATE_W-1:0] RESET_ENC = STATE_W'(RESET_STATE);

  if (NUM_STATES < 2 || NUM_STATES > (1 << STATE_W) ||
      RESET_STATE >= NUM_STATES || DWELL_W < 1) begin : g_param_check
    $error("state_register: illegal parameter combination");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] prev_q, prev_d;
  logic               changed_q, changed_d;
  logic               illegal_q, illegal_d;
  logic               legal;
  logic [STATE_W-1:0] load_val;

  // Illegal requests are redirected to RESET_ENC and then treated like any other load.
  always_comb begin
    legal     = is_legal(32'(next_state), NUM_STATES);
    load_val  = legal ? next_state : RESET_ENC;
    state_d   = state_q;
    prev_d    = prev_q;
    changed_d = 1'b0;
    illegal_d = illegal_q;
    if (clear_illegal) begin
      illegal_d = 1'b0;
    end
    if (en) begin
      if (!legal) begin
        illegal_d = 1'b1;
      end
      if (load_val != state_q) begin
        changed_d = 1'b1;
        prev_d    = state_q;
        state_d   = load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_ENC;
      prev_q    <= RESET_ENC;
      changed_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
      illegal_q <= illegal_d;
    end
  end

  assign current_state = state_q;
  assign prev_state    = prev_q;
  assign state_changed = changed_q;
  assign illegal_flag  = illegal_q;

`ifdef STATE_REGISTER_DWELL_EN
  // Cleared on the same edge that loads a new value, so it reads 0 during the change pulse.
  dwell_counter #(
    .W(DWELL_W)
  ) u_dwell_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (changed_d),
    .count(dwell_count)
  );
`endif

endmodule

// File: tb/tb_state_register.sv
// Self-checking bench for state_register (NUM_STATES=6, DWELL_W=4); dwell checks run when
// STATE_REGISTER_DWELL_EN is defined.
module tb_state_register;

  localparam int SW   = 3;
  localparam int NS   = 6;
  localparam int RS   = 0;
  localparam int DW   = 4;
  localparam int DMAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [SW-1:0] next_state = '0;
  logic          clear_illegal = 1'b0;
  logic [SW-1:0] current_state;
  logic [SW-1:0] prev_state;
  logic          state_changed;
  logic          illegal_flag;
`ifdef STATE_REGISTER_DWELL_EN
  logic [DW-1:0] dwell_count;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: behaviour described as plain integers.
  int mCur = RS, mPrev = RS, mChg = 0, mIll = 0, mDwell = 0;

  state_register #(
    .STATE_W    (SW),
    .NUM_STATES (NS),
    .RESET_STATE(RS),
    .DWELL_W    (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .next_state   (next_state),
    .clear_illegal(clear_illegal),
    .current_state(current_state),
    .prev_state   (prev_state),
    .state_changed(state_changed),
    .illegal_flag (illegal_flag)
`ifdef STATE_REGISTER_DWELL_EN
    ,
    .dwell_count  (dwell_count)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, land 1 ns after it.
  task automatic step(input logic r, input logic e, input int n, input logic c);
    int target;
    reset         = r;
    en            = e;
    next_state    = SW'(n);
    clear_illegal = c;
    @(posedge clk);
    if (r) begin
      mCur = RS; mPrev = RS; mChg = 0; mIll = 0; mDwell = 0;
    end else begin
      target = (n < NS) ? n : RS;
      if (c) mIll = 0;
      if (e && n >= NS) mIll = 1;
      mChg = (e && target != mCur) ? 1 : 0;
      if (mChg == 1) begin
        mPrev = mCur;
        mCur = target;
        mDwell = 0;
      end else if (mDwell < DMAX) begin
        mDwell = mDwell + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 5, 0);
    step(1, 1, 5, 0);
    total++; if (current_state !== 3'd0) begin bad++; $display("[TB] FAIL reset_cur got=%0d exp=0", current_state); end
    total++; if (prev_state !== 3'd0) begin bad++; $display("[TB] FAIL reset_prev got=%0d exp=0", prev_state); end
    total++; if (state_changed !== 1'b0) begin bad++; $display("[TB] FAIL reset_chg got=%0b exp=0", state_changed); end
    total++; if (illegal_flag !== 1'b0) begin bad++; $display("[TB] FAIL reset_ill got=%0b exp=0", illegal_flag); end
`ifdef STATE_REGISTER_DWELL_EN
    total++; if (dwell_count !== 4'd0) begin bad++; $display("[TB] FAIL reset_dwell got=%0d exp=0", dwell_count); end
`endif
    step(0, 0, 5, 0);
    total++; if (state_changed !== 1'b0) begin bad++; $display("[TB] FAIL release_chg got=%0b exp=0", state_changed); end
  endtask

  task automatic test_load_change();
    step(0, 1, 3, 0);
    total++; if (current_state !== 3'd3) begin bad++; $display("[TB] FAIL load_cur got=%0d exp=3", current_state); end
    total++; if (prev_state !== 3'd0) begin bad++; $display("[TB] FAIL load_prev got=%0d exp=0", prev_state); end
    total++; if (state_changed !== 1'b1) begin bad++; $display("[TB] FAIL load_chg got=%0b exp=1", state_changed); end
    step(0, 0, 1, 0);
    total++; if (state_changed !== 1'b0) begin bad++; $display("[TB] FAIL load_chg_after got=%0b exp=0", state_changed); end
    total++; if (current_state !== 3'd3) begin bad++; $display("[TB] FAIL load_hold got=%0d exp=3", current_state); end
  endtask

  task automatic test_illegal();
    step(0, 1, 2, 0);
    step(0, 1, 7, 0);
    total++; if (current_state !== 3'd0) begin bad++; $display("[TB] FAIL ill_cur got=%0d exp=0", current_state); end
    total++; if (prev_state !== 3'd2) begin bad++; $display("[TB] FAIL ill_prev got=%0d exp=2", prev_state); end
    total++; if (illegal_flag !== 1'b1) begin bad++; $display("[TB] FAIL ill_flag got=%0b exp=1", illegal_flag); end
    total++; if (state_changed !== 1'b1) begin bad++; $display("[TB] FAIL ill_chg got=%0b exp=1", state_changed); end
    step(0, 0, 1, 0);
    total++; if (illegal_flag !== 1'b1) begin bad++; $display("[TB] FAIL ill_sticky got=%0b exp=1", illegal_flag); end
    step(0, 1, 6, 1);
    total++; if (illegal_flag !== 1'b1) begin bad++; $display("[TB] FAIL ill_wins_clear got=%0b exp=1", illegal_flag); end
    total++; if (state_changed !== 1'b0) begin bad++; $display("[TB] FAIL ill_same_chg got=%0b exp=0", state_changed); end
    step(0, 0, 6, 1);
    total++; if (illegal_flag !== 1'b0) begin bad++; $display("[TB] FAIL ill_clear got=%0b exp=0", illegal_flag); end
  endtask

  task automatic test_hold_same();
    step(0, 1, 4, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (current_state !== 3'd4 || state_changed !== 1'b0 || prev_state !== 3'd0) begin
        bad++;
        $display("[TB] FAIL hold cyc=%0d cur=%0d chg=%0b prev=%0d exp cur=4 chg=0 prev=0",
                 i, current_state, state_changed, prev_state);
      end
      if (i < 4) step(0, 0, 1, 0);
    end
    step(0, 1, 4, 0);
    total++;
    if (current_state !== 3'd4 || state_changed !== 1'b0 || prev_state !== 3'd0) begin
      bad++;
      $display("[TB] FAIL same_load cur=%0d chg=%0b prev=%0d exp cur=4 chg=0 prev=0",
               current_state, state_changed, prev_state);
    end
  endtask

`ifdef STATE_REGISTER_DWELL_EN
  task automatic test_dwell();
    int peak = 0;
    step(0, 1, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, (i % 3 == 0), 1, 0);
      if (int'(dwell_count) > peak) peak = int'(dwell_count);
      total++;
      if (dwell_count !== DW'(mDwell)) begin
        bad++; $display("[TB] FAIL dwell cyc=%0d got=%0d exp=%0d", i, dwell_count, mDwell);
      end
    end
    total++; if (peak != 15 || dwell_count !== 4'd15) begin bad++; $display("[TB] FAIL dwell_sat got=%0d peak=%0d exp=15", dwell_count, peak); end
    step(0, 1, 2, 0);
    total++; if (dwell_count !== 4'd0) begin bad++; $display("[TB] FAIL dwell_clr got=%0d exp=0", dwell_count); end
  endtask
`endif

  task automatic test_reset_mid();
    step(0, 1, 7, 0);
    step(0, 1, 5, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 2, 0);
    total++; if (current_state !== 3'd5 || illegal_flag !== 1'b1) begin bad++; $display("[TB] FAIL mid_setup cur=%0d ill=%0b exp cur=5 ill=1", current_state, illegal_flag); end
`ifdef STATE_REGISTER_DWELL_EN
    total++; if (dwell_count !== 4'd9) begin bad++; $display("[TB] FAIL mid_dwell got=%0d exp=9", dwell_count); end
`endif
    step(1, 1, 3, 0);
    total++;
    if (current_state !== 3'd0 || prev_state !== 3'd0 || state_changed !== 1'b0 || illegal_flag !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset cur=%0d prev=%0d chg=%0b ill=%0b exp all 0",
               current_state, prev_state, state_changed, illegal_flag);
    end
`ifdef STATE_REGISTER_DWELL_EN
    total++; if (dwell_count !== 4'd0) begin bad++; $display("[TB] FAIL mid_reset_dwell got=%0d exp=0", dwell_count); end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 7),
           ($urandom_range(0, 5) == 0));
      total++;
      if (current_state !== SW'(mCur) || prev_state !== SW'(mPrev) ||
          state_changed !== mChg[0] || illegal_flag !== mIll[0]) begin
        bad++;
        $display("[TB] FAIL rand cyc=%0d got cur=%0d prev=%0d chg=%0b ill=%0b exp cur=%0d prev=%0d chg=%0d ill=%0d",
                 i, current_state, prev_state, state_changed, illegal_flag, mCur, mPrev, mChg, mIll);
      end
`ifdef STATE_REGISTER_DWELL_EN
      total++;
      if (dwell_count !== DW'(mDwell)) begin
        bad++; $display("[TB] FAIL rand_dwell cyc=%0d got=%0d exp=%0d", i, dwell_count, mDwell);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_load_change();
    test_illegal();
    test_hold_same();
`ifdef STATE_REGISTER_DWELL_EN
    test_dwell();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
